brus16_fetch: RTL and testbench
===============================

// Module: brus16_fetch
// PURPOSE
//  Instruction fetch stage for the brus16 core. Owns the program counter and drives the
//  16-bit x 8K program pROM (bypass read mode, 1-cycle read latency). Buffers returned words
//  in a small FIFO and presents them to decode with a valid/ready handshake. Redirects on jumps.
// PARAMETERS
//  ADDR_W     13      ROM word-address width; PC width
//  DATA_W     16      instruction width
//  FIFO_DEPTH 2       instruction buffer entries (>=2 needed for 1 instr/cycle)
//  RESET_PC   13'h0   PC loaded on reset
// PORTS
//  clk          in   1       single clock, all state on rising edge
//  reset        in   1       synchronous, active-high
//  rom_ad       out  ADDR_W  ROM address, combinational, sampled by ROM at clk edge
//  rom_ce       out  1       ROM clock enable; 1 only when a fetch is issued this cycle
//  rom_oce      out  1       tied 1 (ignored in bypass mode)
//  rom_reset    out  1       = reset
//  rom_dout     in   DATA_W  ROM data, valid in cycle after issue
//  jump_valid   in   1       redirect request from execute, single-cycle pulse
//  jump_addr    in   ADDR_W  redirect target
//  instr_valid  out  1       instr_data/instr_pc hold a valid instruction
//  instr_ready  in   1       decode accepts; transfer when valid&ready
//  instr_data   out  DATA_W  instruction word (FIFO head)
//  instr_pc     out  ADDR_W  address the word was fetched from
// BEHAVIOUR
//  - Reset: pc=RESET_PC, FIFO empty, inflight=0, instr_valid=0, instr_data=0, instr_pc=0, rom_ce=0.
//  - FSM: S_RESET (1st cycle after reset deasserts, no issue) -> S_RUN. reset in any state -> S_RESET.
//  - Issue in S_RUN when (fifo_count + inflight - pop) < FIFO_DEPTH, pop = instr_valid & instr_ready.
//    Issue: rom_ce=1, rom_ad=pc; pc<=pc+1 (wraps 2^ADDR_W-1 -> 0); inflight<=1, inflight_pc<=pc.
//  - Return: cycle after issue, rom_dout + inflight_pc pushed into FIFO at the end of that cycle.
//  - Latency: issue in cycle N -> instr_valid in N+2. Steady state 1 instr/cycle with ready=1.
//  - Outputs driven from FIFO head registers; hold stable while valid & !ready.
//  - Push and pop in the same cycle on a full FIFO are legal; count unchanged.
//  - Redirect (jump_valid in cycle N, S_RUN): FIFO flushed and in-flight word discarded at end of N;
//    rom_ad=jump_addr, rom_ce=1 in N (combinational); pc<=jump_addr+1; first target instr valid in N+2.
//    instr_valid=0 in N+1. Handshake in cycle N is still honoured (pop counts).
//  - jump_valid in S_RESET: pc<=jump_addr, no issue; fetch begins from it in S_RUN.
//  - jump_valid together with reset: reset wins.
//  - Never more than one word in flight; FIFO never overflows (credit rule above).
// CONFIGURATION
//  BRUS16_FETCH_PERF_EN defined: adds outputs perf_fetched[31:0] (incremented per FIFO push)
//    and perf_flushes[15:0] (incremented per jump_valid in S_RUN, incl. when no word is discarded);
//    both cleared by reset, wrap at max. Not defined: ports and counters absent, no other change.
// STRUCTURE
//  brus16_pkg: ADDR_W/DATA_W defaults, fetch state enum (S_RESET, S_RUN).
//  Sub-module brus16_fetch_fifo: sync FIFO {pc,data}, DEPTH param, push/pop/flush, count, head outputs.
//  Top: PC register, FSM, credit/issue logic, in-flight tracking, optional perf counters.
// TESTING
//  1. Reset released, ready=1, ROM[0..3]=A,B,C,D -> instr_valid at cycle 2 after S_RUN, then A,B,C,D back-to-back, pc 0,1,2,3.
//  2. ready=0 for 5 cycles mid-stream -> FIFO fills to 2, rom_ce=0, outputs stable; ready=1 -> next word continues, none lost/duplicated.
//  3. jump_valid with jump_addr=0x100 while FIFO full -> instr_valid=0 next cycle, then ROM[0x100] with instr_pc=0x100.
//  4. pc=0x1FFF fetching -> next instr_pc=0x0000 (wrap).
//  5. Jumps on two consecutive cycles (0x10 then 0x20) -> only 0x20 stream appears; nothing from 0x10.
//  6. reset asserted mid-stream with jump_valid=1 -> all outputs to reset values, fetch restarts at RESET_PC; perf counters zeroed (PERF_EN).

Source files
------------

// File: rtl/brus16_pkg.sv
// brus16 shared definitions: default widths and the fetch-stage state encoding.
// Imported by the fetch stage and its instruction buffer.
package brus16_pkg;

    localparam int ADDR_W_DEF = 13;
    localparam int DATA_W_DEF = 16;

    typedef enum logic {
        S_RESET = 1'b0,
        S_RUN   = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/brus16_fetch_fifo.sv
// brus16 fetch instruction buffer: shift-style sync FIFO of {pc,data} words.
// Entry 0 is always the head, so decode sees plain register outputs.
module brus16_fetch_fifo
    import brus16_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = ADDR_W_DEF + DATA_W_DEF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic                           pop,
    input  logic                           flush,
    input  logic [W-1:0]                   wdata,
    output logic [W-1:0]                   head,
    output logic [$clog2(DEPTH + 1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [CW-1:0] wr_idx;

    // a popped slot frees up before the push lands
    assign wr_idx = count - CW'(pop);
    assign head   = mem[0];

    // shift down on pop, write incoming word behind the survivors
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            count <= '0;
        end else begin
            count <= count + CW'(push) - CW'(pop);
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (pop) begin
                    mem[i] <= mem[i+1];
                end
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (push && wr_idx == CW'(i)) begin
                    mem[i] <= wdata;
                end
            end
        end
    end

endmodule

// File: rtl/brus16_fetch.sv
// brus16 fetch stage: PC, pROM issue with credit flow control, jump redirect.
// Define BRUS16_FETCH_PERF_EN to add perf_fetched/perf_flushes counters.
module brus16_fetch
    import brus16_pkg::*;
#(
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter int                DATA_W     = DATA_W_DEF,
    parameter int                FIFO_DEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] rom_ad,
    output logic              rom_ce,
    output logic              rom_oce,
    output logic              rom_reset,
    input  logic [DATA_W-1:0] rom_dout,
    input  logic              jump_valid,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc
`ifdef BRUS16_FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [15:0]       perf_flushes
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;
    logic              pop;
    logic              push;
    logic              flush;
    logic              credit;
    logic              issue;
    logic [CW-1:0]     count;
    logic [ADDR_W+DATA_W-1:0] head;

    assign pop   = instr_valid & instr_ready;
    assign flush = !reset && state == S_RUN && jump_valid;
    // a returning word is dropped when a redirect lands in the same cycle
    assign push  = !reset && inflight && !flush;
    // slots already promised (buffered + in flight) must leave room
    assign credit = (int'(count) + int'(inflight) - int'(pop)) < FIFO_DEPTH;
    assign issue  = !reset && state == S_RUN && (jump_valid || credit);

    assign rom_oce   = 1'b1;
    assign rom_reset = reset;

    // redirect target goes straight to the ROM in the jump cycle
    always_comb begin
        rom_ce = issue;
        rom_ad = flush ? jump_addr : pc;
    end

    assign instr_valid = (count != '0);
    assign {instr_pc, instr_data} = head;

    brus16_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ADDR_W + DATA_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata ({inflight_pc, rom_dout}),
        .head  (head),
        .count (count)
    );

    // state, pc and in-flight tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_RESET;
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight <= issue;
            unique case (state)
                S_RESET: begin
                    state <= S_RUN;
                    if (jump_valid) begin
                        pc <= jump_addr;
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        pc          <= jump_addr + ADDR_W'(1);
                        inflight_pc <= jump_addr;
                    end else if (issue) begin
                        pc          <= pc + ADDR_W'(1);
                        inflight_pc <= pc;
                    end
                end
                default: state <= S_RESET;
            endcase
        end
    end

`ifdef BRUS16_FETCH_PERF_EN
    // free-running event counters, wrap at max
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_flushes <= '0;
        end else begin
            if (push) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (flush) begin
                perf_flushes <= perf_flushes + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_brus16_fetch.sv
// Self-checking bench for brus16_fetch: ROM model plus an in-order
// expected-address model of the instruction stream.
module tb_brus16_fetch;

    localparam int AW = 13;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] rom_ad;
    logic          rom_ce;
    logic          rom_oce;
    logic          rom_reset;
    logic [DW-1:0] rom_dout;
    logic          jump_valid;
    logic [AW-1:0] jump_addr;
    logic          instr_valid;
    logic          instr_ready;
    logic [DW-1:0] instr_data;
    logic [AW-1:0] instr_pc;
`ifdef BRUS16_FETCH_PERF_EN
    logic [31:0]   perf_fetched;
    logic [15:0]   perf_flushes;
`endif

    logic [DW-1:0] rom [0:(1<<AW)-1];

    int checks   = 0;
    int failures = 0;

    logic [AW-1:0] exp_pc;
    bit            in_run;
    bit            after_jump;
    int            accepted;
    int            flushes;
    int            acc0;

    always #5 clk = ~clk;

    // synchronous ROM: data appears the cycle after the enabled edge
    always @(posedge clk) begin
        if (rom_ce) begin
            rom_dout <= rom[rom_ad];
        end
    end

    brus16_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .rom_ad      (rom_ad),
        .rom_ce      (rom_ce),
        .rom_oce     (rom_oce),
        .rom_reset   (rom_reset),
        .rom_dout    (rom_dout),
        .jump_valid  (jump_valid),
        .jump_addr   (jump_addr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_data  (instr_data),
        .instr_pc    (instr_pc)
`ifdef BRUS16_FETCH_PERF_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_flushes(perf_flushes)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // one clock: check the stream against the model, then advance
    task automatic cyc();
        @(negedge clk);
        if (!reset) begin
            if (after_jump) begin
                chk("valid_after_jump", 32'(instr_valid), 32'd0);
            end
            if (instr_valid) begin
                chk("head_pc", 32'(instr_pc), 32'(exp_pc));
                chk("head_data", 32'(instr_data), 32'(rom[exp_pc]));
                if (instr_ready) begin
                    exp_pc = exp_pc + 1'b1;
                    accepted++;
                end
            end
            if (jump_valid && in_run) begin
                chk("jump_rom_ce", 32'(rom_ce), 32'd1);
                chk("jump_rom_ad", 32'(rom_ad), 32'(jump_addr));
            end
            if (!in_run) begin
                chk("s_reset_no_issue", 32'(rom_ce), 32'd0);
            end
        end
        after_jump = !reset && jump_valid && in_run;
        if (after_jump) begin
            flushes++;
        end
        if (!reset && jump_valid) begin
            exp_pc = jump_addr;
        end
        if (reset) begin
            in_run = 1'b0;
            exp_pc = '0;
            flushes = 0;
        end else begin
            in_run = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state();
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_data", 32'(instr_data), 32'd0);
        chk("rst_pc", 32'(instr_pc), 32'd0);
        chk("rst_rom_ce", 32'(rom_ce), 32'd0);
        chk("rst_rom_reset", 32'(rom_reset), 32'd1);
`ifdef BRUS16_FETCH_PERF_EN
        chk("rst_perf_fetched", perf_fetched, 32'd0);
        chk("rst_perf_flushes", 32'(perf_flushes), 32'd0);
`endif
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            rom[i] = 16'($urandom);
        end
        rom_dout    = '0;
        reset       = 1'b1;
        jump_valid  = 1'b0;
        jump_addr   = '0;
        instr_ready = 1'b1;
        in_run      = 1'b0;
        after_jump  = 1'b0;
        exp_pc      = '0;
        accepted    = 0;
        flushes     = 0;

        // reset state
        cyc();
        cyc();
        chk_reset_state();
        chk("rom_oce", 32'(rom_oce), 32'd1);

        // release: S_RESET, first issue, latency, back-to-back stream
        reset = 1'b0;
        chk("rom_reset_low", 32'(rom_reset), 32'd0);
        chk("s_reset_ce", 32'(rom_ce), 32'd0);
        cyc();
        chk("first_issue_ce", 32'(rom_ce), 32'd1);
        chk("first_issue_ad", 32'(rom_ad), 32'd0);
        cyc();
        chk("latency_not_yet", 32'(instr_valid), 32'd0);
        cyc();
        for (int i = 0; i < 4; i++) begin
            chk("stream_valid", 32'(instr_valid), 32'd1);
            chk("stream_pc", 32'(instr_pc), 32'(i));
            cyc();
        end

        // stall five cycles: buffer fills, no issue, head held
        instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i >= 1) begin
                chk("stall_rom_ce", 32'(rom_ce), 32'd0);
                chk("stall_valid", 32'(instr_valid), 32'd1);
            end
            cyc();
        end
        instr_ready = 1'b1;
        acc0 = accepted;
        for (int i = 0; i < 6; i++) begin
            cyc();
        end
        chk("resume_count", 32'(accepted - acc0), 32'd6);

        // jump to 0x100 with a full buffer
        instr_ready = 1'b0;
        cyc();
        cyc();
        cyc();
        chk("full_before_jump", 32'(instr_valid), 32'd1);
        jump_valid = 1'b1;
        jump_addr  = 13'h100;
        cyc();
        jump_valid  = 1'b0;
        instr_ready = 1'b1;
        cyc();
        chk("jump_tgt_valid", 32'(instr_valid), 32'd1);
        chk("jump_tgt_pc", 32'(instr_pc), 32'h100);
        for (int i = 0; i < 4; i++) begin
            cyc();
        end

        // address wrap at the top of the ROM
        jump_valid = 1'b1;
        jump_addr  = 13'h1FFD;
        cyc();
        jump_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
        end
        chk("wrap_valid", 32'(instr_valid), 32'd1);
        chk("wrap_pc", 32'(instr_pc), 32'h0);
        cyc();
        cyc();

        // back-to-back jumps: only the second target streams
        jump_valid = 1'b1;
        jump_addr  = 13'h10;
        cyc();
        jump_addr  = 13'h20;
        cyc();
        jump_valid = 1'b0;
        cyc();
        chk("dbl_jump_valid", 32'(instr_valid), 32'd1);
        chk("dbl_jump_pc", 32'(instr_pc), 32'h20);
        for (int i = 0; i < 4; i++) begin
            cyc();
        end

        // reset mid-stream with a jump: reset wins
        reset      = 1'b1;
        jump_valid = 1'b1;
        jump_addr  = 13'h33;
        cyc();
        chk_reset_state();
        reset      = 1'b0;
        jump_valid = 1'b0;
        cyc();
        chk("restart_ce", 32'(rom_ce), 32'd1);
        chk("restart_ad", 32'(rom_ad), 32'd0);
        cyc();
        cyc();
        chk("restart_pc", 32'(instr_pc), 32'd0);
        cyc();

        // jump during S_RESET loads the pc without issuing
        reset = 1'b1;
        cyc();
        reset      = 1'b0;
        jump_valid = 1'b1;
        jump_addr  = 13'h55;
        cyc();
        jump_valid = 1'b0;
        chk("sreset_jump_ad", 32'(rom_ad), 32'h55);
        chk("sreset_jump_ce", 32'(rom_ce), 32'd1);
        cyc();
        cyc();
        chk("sreset_jump_pc", 32'(instr_pc), 32'h55);

        // randomized ready and jump traffic
        acc0 = accepted;
        for (int i = 0; i < 400; i++) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            jump_valid  = ($urandom_range(0, 15) == 0);
            jump_addr   = AW'($urandom);
            cyc();
        end
        jump_valid  = 1'b0;
        instr_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
        end
        chk("rand_progress", 32'(accepted > acc0 + 100), 32'd1);
        chk("drain_valid", 32'(instr_valid), 32'd1);
`ifdef BRUS16_FETCH_PERF_EN
        chk("perf_flushes", 32'(perf_flushes), 32'(flushes));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
